// File: rtl/instr_fetch_unit.sv
// Sequential instruction-fetch front end: PC register, req/ack instruction-memory
// fetch with timeout, valid/ready hand-off to decode, and next-PC selection.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        instr_ready,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] instret,
  output logic [1:0]  fetch_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic        next_misaligned;
  logic        timed_out;

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = PC;
  assign PCPlus4     = PC + 32'd4;

  // PCSrc=11 falls back to sequential fetch; jalr target drops bit 0.
  always_comb begin
    next_pc = PCPlus4;
    unique case (PCSrc)
      2'b01:   next_pc = PC + ImmExt;
      2'b10:   next_pc = ALUResult & 32'hFFFF_FFFE;
      default: next_pc = PCPlus4;
    endcase
  end

  assign next_misaligned = (next_pc[1:0] != 2'b00);
  assign timed_out       = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      PC        <= RESET_PC;
      instr     <= '0;
      instret   <= '0;
      fetch_err <= ERR_NONE;
      wait_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;

        // An ack on the last allowed wait cycle still wins over the timeout.
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
            state    <= HOLD;
          end else if (timed_out) begin
            fetch_err <= ERR_TIMEOUT;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            if (next_misaligned) begin
              fetch_err <= ERR_MISALIGN;
              state     <= HALT;
            end else begin
              PC      <= next_pc;
              instret <= instret + 32'd1;
              state   <= FETCH;
            end
          end
        end

        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, branch, jalr, wait states,
// timeout, PC wrap and asynchronous reset during HOLD.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        instr_ready;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] instret;
  logic [1:0]  fetch_err;

  int unsigned vectors;
  int unsigned miscompares;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .instr_ready(instr_ready), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr), .instr_valid(instr_valid),
    .PC(PC), .PCPlus4(PCPlus4), .instret(instret), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges, then releases it just after an edge (state IDLE).
  task automatic do_reset();
    rst_n = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Stimulus only: from FETCH, ack with a word and land in HOLD.
  task automatic fetch_word(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  // Stimulus only: from HOLD, accept the instruction with the given selects.
  task automatic retire(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    instr_ready = 1'b1; PCSrc = src; ImmExt = imm; ALUResult = alu;
    tick();
    instr_ready = 1'b0; PCSrc = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
    tick(); tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0h exp 0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0h exp 0", instr_valid); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %08h exp 00000000", imem_addr); end
    vectors++; if (PCPlus4 !== 32'h4) begin miscompares++; $display("FAIL rst_pcplus4 got %08h exp 00000004", PCPlus4); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %08h exp 00000000", instr); end
    vectors++; if (instret !== 32'h0) begin miscompares++; $display("FAIL rst_instret got %0d exp 0", instret); end
    vectors++; if (fetch_err !== 2'b00) begin miscompares++; $display("FAIL rst_err got %0h exp 0", fetch_err); end
  endtask

  // Reset released with ack already high; the IDLE cycle must ignore it.
  task automatic test_seq_fetch();
    logic [31:0] w;
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0013; instr_ready = 1'b1; PCSrc = 2'b00;
    #2;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req got %0h exp 0", imem_req); end
    tick();
    for (int i = 0; i < 3; i++) begin
      w = 32'h0000_0100 + 32'(i);
      imem_rdata = w;
      vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_req[%0d] got %0h exp 1", i, imem_req); end
      vectors++; if (imem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr[%0d] got %08h exp %08h", i, imem_addr, 32'(4 * i)); end
      tick();
      vectors++; if (instr_valid !== 1'b1 || instr !== w) begin miscompares++; $display("FAIL seq_instr[%0d] got v=%0h %08h exp v=1 %08h", i, instr_valid, instr, w); end
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    vectors++; if (instret !== 32'd3) begin miscompares++; $display("FAIL seq_instret got %0d exp 3", instret); end
    vectors++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_next got req=%0h %08h exp req=1 0000000c", imem_req, imem_addr); end
  endtask

  task automatic test_branch();
    fetch_word(32'h0000_0033);
    retire(2'b00, 32'h0, 32'h0);
    vectors++; if (PC !== 32'h10) begin miscompares++; $display("FAIL br_pre_pc got %08h exp 00000010", PC); end
    fetch_word(32'h0000_0063);
    retire(2'b01, 32'hFFFF_FFF8, 32'h0);
    vectors++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin miscompares++; $display("FAIL br_addr got req=%0h %08h exp req=1 00000008", imem_req, imem_addr); end
    vectors++; if (instret !== 32'd5) begin miscompares++; $display("FAIL br_instret got %0d exp 5", instret); end
  endtask

  task automatic test_wrap();
    fetch_word(32'h0000_006F);
    retire(2'b01, 32'hFFFF_FFF4, 32'h0);
    vectors++; if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got %08h exp fffffffc", PC); end
    vectors++; if (PCPlus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pcplus4 got %08h exp 00000000", PCPlus4); end
    fetch_word(32'h0000_0013);
    retire(2'b00, 32'h0, 32'h0);
    vectors++; if (imem_addr !== 32'h0 || instret !== 32'd7) begin miscompares++; $display("FAIL wrap_next got %08h n=%0d exp 00000000 n=7", imem_addr, instret); end
  endtask

  task automatic test_jalr();
    fetch_word(32'h0000_0067);
    retire(2'b10, 32'h0, 32'h0000_0105);
    vectors++; if (PC !== 32'h104 || instret !== 32'd8) begin miscompares++; $display("FAIL jalr_pc got %08h n=%0d exp 00000104 n=8", PC, instret); end
    fetch_word(32'h0000_DEAD);
    retire(2'b10, 32'h0, 32'h0000_0106);
    vectors++; if (fetch_err !== 2'b01) begin miscompares++; $display("FAIL jalr_err got %0h exp 1", fetch_err); end
    vectors++; if (PC !== 32'h104 || instret !== 32'd8) begin miscompares++; $display("FAIL jalr_hold got %08h n=%0d exp 00000104 n=8", PC, instret); end
    vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL jalr_halt got req=%0h v=%0h exp 0 0", imem_req, instr_valid); end
    imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hFFFF_0000;
    tick(); tick(); tick();
    imem_ack = 1'b0; instr_ready = 1'b0;
    vectors++; if (fetch_err !== 2'b01 || instr !== 32'h0000_DEAD || PC !== 32'h104) begin miscompares++; $display("FAIL jalr_sticky got e=%0h %08h %08h exp e=1 0000dead 00000104", fetch_err, instr, PC); end
  endtask

  task automatic test_wait_stall();
    do_reset();
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || PC !== 32'h0) begin miscompares++; $display("FAIL wait[%0d] got req=%0h v=%0h pc=%08h exp 1 0 0", i, imem_req, instr_valid, PC); end
    end
    instr_ready = 1'b0;
    fetch_word(32'h0000_CAFE);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    tick(); tick();
    imem_ack = 1'b0;
    vectors++; if (instr_valid !== 1'b1 || instr !== 32'h0000_CAFE || PC !== 32'h0) begin miscompares++; $display("FAIL stall got v=%0h %08h pc=%08h exp 1 0000cafe 0", instr_valid, instr, PC); end
    retire(2'b00, 32'h0, 32'h0);
    vectors++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instret !== 32'd1) begin miscompares++; $display("FAIL stall_next got %08h req=%0h n=%0d exp 4 1 1", imem_addr, imem_req, instret); end
  endtask

  // Continues from FETCH at PC=4 with a cleared wait counter.
  task automatic test_timeout();
    tick(); tick(); tick();
    vectors++; if (imem_req !== 1'b1 || fetch_err !== 2'b00) begin miscompares++; $display("FAIL to_early got req=%0h e=%0h exp 1 0", imem_req, fetch_err); end
    tick();
    vectors++; if (imem_req !== 1'b0 || fetch_err !== 2'b10) begin miscompares++; $display("FAIL to_halt got req=%0h e=%0h exp 0 2", imem_req, fetch_err); end
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    vectors++; if (fetch_err !== 2'b10 || imem_req !== 1'b0 || PC !== 32'h4) begin miscompares++; $display("FAIL to_sticky got e=%0h req=%0h pc=%08h exp 2 0 4", fetch_err, imem_req, PC); end
    do_reset();
    vectors++; if (fetch_err !== 2'b00) begin miscompares++; $display("FAIL to_clear got %0h exp 0", fetch_err); end
  endtask

  task automatic test_mid_reset();
    tick();
    fetch_word(32'h0000_0013);
    retire(2'b00, 32'h0, 32'h0);
    fetch_word(32'h0000_5555);
    vectors++; if (instr_valid !== 1'b1 || instret !== 32'd1) begin miscompares++; $display("FAIL mr_pre got v=%0h n=%0d exp 1 1", instr_valid, instret); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mr_out got v=%0h req=%0h %08h exp 0 0 0", instr_valid, imem_req, imem_addr); end
    vectors++; if (instret !== 32'h0 || instr !== 32'h0 || fetch_err !== 2'b00 || PCPlus4 !== 32'h4) begin miscompares++; $display("FAIL mr_regs got n=%0d %08h e=%0h %08h exp 0 0 0 4", instret, instr, fetch_err, PCPlus4); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_seq_fetch();
    test_branch();
    test_wrap();
    test_jalr();
    test_wait_stall();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
